// File: rtl/mult_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: FSM state
// encoding, operand/product widths and the product reported on an abort.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [PROD_W-1:0] ABORT_PRODUCT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: starting just after the last
// winner (ptr), returns the first asserted request as one-hot and as index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int cand;

    // Walk the requesters from ptr+1 around to ptr and keep the first hit
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier among N_REQ
// requesters. IDLE picks a winner and captures its operands, ISSUE pulses
// gnt and mul_start, WAIT holds until mul_ready, DONE pulses done.
// Optional watchdog abort enabled by defining MULT_RR_SCHED_TIMEOUT_EN.
module mult_rr_sched
    import mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [OP_W*N_REQ-1:0]   a_in,
    input  logic [OP_W*N_REQ-1:0]   b_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [PROD_W-1:0]       result,
    output logic                    busy,
    output logic                    err,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [PROD_W-1:0]       mul_product,
    input  logic                    mul_ready
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("mult_rr_sched: N_REQ must be 2..8 and TIMEOUT at least 1");
    end

    state_t           state;
    state_t           next_state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cur_idx;
    logic [PTR_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             pick_valid;
    logic [OP_W-1:0]  sel_a;
    logic [OP_W-1:0]  sel_b;
    logic             wd_expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // AND-OR mux of the winning requester's operand slices
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = sel_a | a_in[i*OP_W +: OP_W];
                sel_b = sel_b | b_in[i*OP_W +: OP_W];
            end
        end
    end

    // State register; reset abandons any job in flight without a done
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pulse outputs; mul_ready only matters once in WAIT,
    // because the multiplier still shows its old ready during the start cycle
    always_comb begin
        next_state = state;
        gnt        = '0;
        done       = '0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state   = WAIT;
                mul_start    = 1'b1;
                gnt[cur_idx] = 1'b1;
            end
            WAIT: begin
                if (mul_ready || wd_expired) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state    = IDLE;
                done[cur_idx] = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Operand capture, winner bookkeeping and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= PTR_W'(N_REQ - 1);
            cur_idx <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        mul_a   <= sel_a;
                        mul_b   <= sel_b;
                        cur_idx <= pick_idx;
                        ptr     <= pick_idx;
                    end
                end
                WAIT: begin
                    if (mul_ready) begin
                        result <= mul_product;
                    end else if (wd_expired) begin
                        result <= ABORT_PRODUCT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULT_RR_SCHED_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [WD_W-1:0] wd_count;
    logic            timed_out;

    assign wd_expired = (state == WAIT) && !mul_ready && (wd_count == WD_W'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles; after TIMEOUT of them the job is abandoned
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count  <= '0;
            timed_out <= 1'b0;
        end else if (state == ISSUE) begin
            wd_count  <= '0;
            timed_out <= 1'b0;
        end else if (state == WAIT && !mul_ready) begin
            if (wd_expired) begin
                timed_out <= 1'b1;
            end else begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end

    assign err = (state == DONE) && timed_out;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

endmodule
